// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch-to-decode buffer.
// Holds default sizes, pointer-width helper and the packed entry type.
package fetch_buffer_pkg;

    localparam int FB_WIDTH = 32;
    localparam int FB_DEPTH = 4;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int fb_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int FB_PTR_W = fb_ptr_w(FB_DEPTH);

    typedef struct packed {
        logic [FB_WIDTH-1:0] instruction;
        logic [FB_WIDTH-1:0] pc;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// Storage for the fetch buffer: DEPTH x DW register array.
// Ports: clock, we_i/waddr_i/wdata_i (sync write), raddr_i/rdata_o (async read).
module fetch_buffer_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset; the empty gating hides them.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction FIFO with flush on taken branch.
// Ports: clock/reset, fetch_* push side, id_* pop side, branch_tacken, occupancy.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int WIDTH = FB_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [WIDTH-1:0]         instruction,
    input  logic [WIDTH-1:0]         pc_value,
    input  logic                     branch_tacken,
    output logic                     fetch_stall,
    output logic                     id_valid,
    output logic [WIDTH-1:0]         id_instruction,
    output logic [WIDTH-1:0]         id_pc,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = fb_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [2*WIDTH-1:0] rd_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A taken branch squashes both sides of the handshake.
    assign push = fetch_valid && !full && !branch_tacken;
    assign pop  = !empty && id_ready && !branch_tacken;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (branch_tacken) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_buffer_mem #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH),
        .AW    (PTR_W)
    ) u_mem (
        .clock   (clock),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({instruction, pc_value}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Stall comes from registered count only; no path from id_ready.
    assign fetch_stall    = full;
    assign id_valid       = !empty;
    assign id_instruction = empty ? '0 : rd_data[2*WIDTH-1:WIDTH];
    assign id_pc          = empty ? '0 : rd_data[WIDTH-1:0];
    assign occupancy      = count_q;

endmodule
